// File: rtl/vend_pkg.sv
// Shared types and constants for the coin front end and the vending FSM.
package vend_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      QUAL = 2'd1,
      HELD = 2'd2,
      RELQ = 2'd3
   } chan_state_e;

   localparam int                  CREDIT_W   = 8;
   localparam logic [CREDIT_W-1:0] NICKEL_VAL = 8'd1;
   localparam logic [CREDIT_W-1:0] DIME_VAL   = 8'd2;

   // Credit is a running total that must pin at full scale rather than wrap.
   function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                   input logic [CREDIT_W-1:0] b);
      logic [CREDIT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CREDIT_W] ? {CREDIT_W{1'b1}} : sum[CREDIT_W-1:0];
   endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-switch channel: two-flop synchronizer, press/release qualifier FSM
// and its down-counter. qual_o is high for the single cycle that commits QUAL->HELD.
//
//   state | meaning
//   IDLE  | switch released and qualified low
//   QUAL  | counting consecutive high samples toward a press
//   HELD  | press qualified, event already issued
//   RELQ  | counting consecutive low samples toward a release
module coin_debounce
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic qual_o
);

   localparam logic [7:0] RELOAD = 8'(DEBOUNCE_CYCLES - 1);

   logic [1:0]  sync_q;
   chan_state_e state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        smp;

   assign smp = sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         sync_q  <= {sync_q[0], raw_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The sample that opens QUAL/RELQ counts as the first of the run.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      qual_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (smp) begin
               state_d = QUAL;
               cnt_d   = RELOAD;
            end
         end
         QUAL: begin
            if (!smp) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else if (cnt_q == 8'd1) begin
               state_d = HELD;
               cnt_d   = 8'd0;
               qual_o  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         HELD: begin
            if (!smp) begin
               state_d = RELQ;
               cnt_d   = RELOAD;
            end
         end
         RELQ: begin
            if (smp) begin
               state_d = HELD;
               cnt_d   = 8'd0;
            end else if (cnt_q == 8'd1) begin
               state_d = IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

endmodule

// File: rtl/coin_conditioner.sv
// Coin front end: two debounced channels, dime-first arbitration with a
// one-deep nickel pending flag, and the saturating credit accumulator.
module coin_conditioner
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                nickel_raw,
   input  logic                dime_raw,
   input  logic                credit_clr,
   output logic                nickel_pulse,
   output logic                dime_pulse,
   output logic [CREDIT_W-1:0] credit
);

   logic                nickel_qual, dime_qual;
   logic                nickel_pulse_q, nickel_pulse_d;
   logic                dime_pulse_q, dime_pulse_d;
   logic                pend_q, pend_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] credit_base;

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (nickel_raw),
      .qual_o (nickel_qual)
   );

   coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_i  (dime_raw),
      .qual_o (dime_qual)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nickel_pulse_q <= 1'b0;
         dime_pulse_q   <= 1'b0;
         pend_q         <= 1'b0;
         credit_q       <= '0;
      end else begin
         nickel_pulse_q <= nickel_pulse_d;
         dime_pulse_q   <= dime_pulse_d;
         pend_q         <= pend_d;
         credit_q       <= credit_d;
      end
   end

   // Dime wins a tie; a deferred nickel goes out the following cycle.
   always_comb begin
      dime_pulse_d   = dime_qual;
      nickel_pulse_d = 1'b0;
      pend_d         = pend_q;
      if (dime_qual) begin
         pend_d = pend_q | nickel_qual;
      end else if (pend_q) begin
         nickel_pulse_d = 1'b1;
         pend_d         = 1'b0;
      end else begin
         nickel_pulse_d = nickel_qual;
      end
   end

   // Clear is applied before the coin value so a coin landing with a clear is kept.
   always_comb begin
      credit_base = credit_clr ? '0 : credit_q;
      credit_d    = credit_base;
      if (nickel_pulse_q) begin
         credit_d = sat_add(credit_base, NICKEL_VAL);
      end else if (dime_pulse_q) begin
         credit_d = sat_add(credit_base, DIME_VAL);
      end
   end

   assign nickel_pulse = nickel_pulse_q;
   assign dime_pulse   = dime_pulse_q;
   assign credit       = credit_q;

endmodule

// File: tb/tb_coin_conditioner.sv
// Bench for coin_conditioner at DEBOUNCE_CYCLES=4: vector table of press
// patterns plus hand sequences for saturation, clear and reset corners.
module tb_coin_conditioner;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       nickel_raw = 1'b0;
   logic       dime_raw = 1'b0;
   logic       credit_clr = 1'b0;
   logic       nickel_pulse;
   logic       dime_pulse;
   logic [7:0] credit;

   coin_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .nickel_raw   (nickel_raw),
      .dime_raw     (dime_raw),
      .credit_clr   (credit_clr),
      .nickel_pulse (nickel_pulse),
      .dime_pulse   (dime_pulse),
      .credit       (credit)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      int   edge_no;
      logic dime;
   } ev_t;

   // Raw levels per relative edge: nickel high in [n_a0,n_a1) or [n_b0,n_b1);
   // dime toggles (high on even edges) below d_tog, else high in [d_a0,d_a1).
   // Up to two expected events (e*, kind 1 = dime), a mid-run credit check, final credit.
   typedef struct {
      int len;
      int n_a0, n_a1, n_b0, n_b1;
      int d_tog, d_a0, d_a1;
      int e0, k0, e1, k1;
      int c_edge, c_exp;
      int fin;
   } vec_t;

   ev_t  sb[$];
   int   vecs = 0;
   int   errs = 0;
   int   edge_no = 0;
   int   last = 0;
   vec_t vt[8];

   function automatic vec_t mk(input int len, input int na0, input int na1, input int nb0,
                               input int nb1, input int dtog, input int da0, input int da1,
                               input int e0, input int k0, input int e1, input int k1,
                               input int ce, input int cx, input int fin);
      vec_t v;
      v.len = len; v.n_a0 = na0; v.n_a1 = na1; v.n_b0 = nb0; v.n_b1 = nb1;
      v.d_tog = dtog; v.d_a0 = da0; v.d_a1 = da1;
      v.e0 = e0; v.k0 = k0; v.e1 = e1; v.k1 = k1;
      v.c_edge = ce; v.c_exp = cx; v.fin = fin;
      return v;
   endfunction

   task automatic push_ev(input int abs_edge, input logic is_dime);
      ev_t e;
      e.edge_no = abs_edge;
      e.dime    = is_dime;
      sb.push_back(e);
   endtask

   task automatic pop_cmp(input int cur, input logic is_dime);
      ev_t e;
      vecs++;
      if (sb.size() == 0) begin
         errs++;
         $display("FAIL unexpected_pulse: %s pulse at edge %0d, none required",
                  is_dime ? "dime" : "nickel", cur);
      end else begin
         e = sb.pop_front();
         if (e.edge_no != cur || e.dime != is_dime) begin
            errs++;
            $display("FAIL pulse_event: got %s at edge %0d, required %s at edge %0d",
                     is_dime ? "dime" : "nickel", cur, e.dime ? "dime" : "nickel", e.edge_no);
         end
      end
   endtask

   task automatic mon(input int cur, input logic r);
      if (nickel_pulse && dime_pulse) begin
         errs++;
         $display("FAIL exclusive: both pulses high at edge %0d", cur);
      end
      if (dime_pulse)   pop_cmp(cur, 1'b1);
      if (nickel_pulse) pop_cmp(cur, 1'b0);
      if (!r) begin
         vecs++;
         if (nickel_pulse || dime_pulse || credit != 8'd0) begin
            errs++;
            $display("FAIL reset_outputs: edge %0d got n=%0b d=%0b credit=%0d, required 0/0/0",
                     cur, nickel_pulse, dime_pulse, credit);
         end
      end
   endtask

   task automatic step(input logic n, input logic d, input logic c, input logic r);
      nickel_raw = n;
      dime_raw   = d;
      credit_clr = c;
      rst_n      = r;
      @(posedge clk);
      #1;
      last = edge_no;
      edge_no++;
      mon(last, r);
   endtask

   task automatic chk_credit(input string name, input int exp);
      vecs++;
      if (credit != 8'(exp)) begin
         errs++;
         $display("FAIL %s: credit got %0d, required %0d (edge %0d)", name, credit, exp, last);
      end
   endtask

   task automatic chk_drained(input string name);
      vecs++;
      if (sb.size() != 0) begin
         errs++;
         $display("FAIL %s: %0d required pulse(s) never seen, next at edge %0d",
                  name, sb.size(), sb[0].edge_no);
         sb.delete();
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic prep();
      step(1'b0, 1'b0, 1'b1, 1'b1);
      idle(11);
   endtask

   // One coin: raw high for 'hold' steps out of 'total', credit_clr on step clr_at.
   task automatic press(input logic is_dime, input int hold, input int clr_at, input int total);
      int base;
      base = edge_no;
      push_ev(base + N + 1, is_dime);
      for (int i = 0; i < total; i++) begin
         step(!is_dime && i < hold, is_dime && i < hold, i == clr_at, 1'b1);
      end
   endtask

   initial begin
      vt[0] = mk(24,  0, 20,  0,  0,  0,  0,  0,  5, 0, -1, 0,  6, 1, 1); // clean nickel
      vt[1] = mk(28,  0,  0,  0,  0, 10, 10, 25, 15, 1, -1, 0, 16, 2, 2); // bouncing dime
      vt[2] = mk(24,  0, 20,  0,  0,  0,  0, 20,  5, 1,  6, 0,  7, 3, 3); // simultaneous
      vt[3] = mk(34,  0, 10, 12, 30,  0,  0,  0,  5, 0, -1, 0,  6, 1, 1); // 2-cycle release
      vt[4] = mk(34,  0, 10, 14, 30,  0,  0,  0,  5, 0, 19, 0, 19, 1, 2); // 4-cycle release
      vt[5] = mk(14,  0,  3,  0,  0,  0,  0,  0, -1, 0, -1, 0,  6, 0, 0); // 3-sample glitch
      vt[6] = mk(14,  0,  4,  0,  0,  0,  0,  0,  5, 0, -1, 0,  5, 0, 1); // exactly 4 samples
      vt[7] = mk(24, 10, 16,  0,  0,  0,  0,  6,  5, 1, 15, 0, 16, 3, 3); // dime then nickel

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      idle(4);
      chk_credit("reset_credit", 0);

      foreach (vt[v]) begin
         int   base;
         logic n, d;
         prep();
         base = edge_no;
         if (vt[v].e0 >= 0) push_ev(base + vt[v].e0, vt[v].k0 != 0);
         if (vt[v].e1 >= 0) push_ev(base + vt[v].e1, vt[v].k1 != 0);
         for (int rel = 0; rel < vt[v].len; rel++) begin
            n = (rel >= vt[v].n_a0 && rel < vt[v].n_a1) || (rel >= vt[v].n_b0 && rel < vt[v].n_b1);
            d = (rel < vt[v].d_tog) ? (rel % 2 == 0) : (rel >= vt[v].d_a0 && rel < vt[v].d_a1);
            step(n, d, 1'b0, 1'b1);
            if (rel == vt[v].c_edge) chk_credit($sformatf("vec%0d_mid_credit", v), vt[v].c_exp);
         end
         chk_drained($sformatf("vec%0d_events", v));
         chk_credit($sformatf("vec%0d_final_credit", v), vt[v].fin);
      end

      // Saturation: 127 dimes to 254, one more to 255, a nickel held at 255.
      prep();
      for (int i = 0; i < 127; i++) press(1'b1, 6, -1, 12);
      chk_credit("sat_254", 254);
      press(1'b1, 6, -1, 12);
      chk_credit("sat_dime_255", 255);
      press(1'b0, 6, -1, 12);
      chk_credit("sat_nickel_255", 255);
      // Nickel pulse at step 5 coincides with credit_clr sampled on step 6.
      press(1'b0, 6, 6, 7);
      chk_credit("clr_with_nickel", 1);
      idle(8);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk_credit("clr_alone", 0);
      chk_drained("sat_events");
      idle(4);

      // Reset mid-qualification with the switch still held.
      begin
         int base;
         base = edge_no;
         push_ev(base + 10, 1'b0);
         for (int rel = 0; rel < 20; rel++) begin
            step(1'b1, 1'b0, 1'b0, !(rel == 3 || rel == 4));
            if (rel == 9)  chk_credit("rst_qual_before", 0);
            if (rel == 11) chk_credit("rst_qual_after", 1);
         end
         idle(10);
         chk_drained("rst_qual_events");
      end

      // Reset while the nickel is pending behind a dime; both still held.
      begin
         int base;
         base = edge_no;
         push_ev(base + 5, 1'b1);
         push_ev(base + 13, 1'b1);
         push_ev(base + 14, 1'b0);
         for (int rel = 0; rel < 20; rel++) step(1'b1, 1'b1, 1'b0, !(rel == 6 || rel == 7));
         chk_credit("rst_pend_credit", 3);
         idle(10);
         chk_drained("rst_pend_events");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/coin_conditioner.md
COIN_CONDITIONER -- requirements
Module: coin_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8, sets the number of consecutive equal synchronized samples that qualify a press or a release; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 nickel_raw  input  1  raw, asynchronous nickel coin-switch level; may bounce.
REQ-005 dime_raw  input  1  raw, asynchronous dime coin-switch level; may bounce.
REQ-006 credit_clr  input  1  synchronous request from the vending FSM to zero credit after a dispense.
REQ-007 nickel_pulse  output  1  one-cycle, clean nickel event to the vending FSM.
REQ-008 dime_pulse  output  1  one-cycle, clean dime event to the vending FSM.
REQ-009 credit  output  8  accumulated credit in nickel units; saturates at 255.

Function
REQ-010 Each raw input SHALL pass through a two-flop synchronizer before any other logic samples it.
REQ-011 Each channel SHALL run its own FSM:
  - IDLE -> QUAL on a synchronized high.
  - QUAL -> HELD after DEBOUNCE_CYCLES consecutive high samples.
  - QUAL -> IDLE on any low sample, with the counter cleared.
  - HELD -> RELQ on a low sample.
  - RELQ -> IDLE after DEBOUNCE_CYCLES consecutive low samples.
  - RELQ -> HELD on any high sample.
REQ-012 A channel SHALL emit its qualified event only on the QUAL->HELD transition, so one insertion produces exactly one event however long the switch is held.
REQ-013 With raw high captured at edge 0, the event pulse SHALL go high at edge 1+DEBOUNCE_CYCLES and last exactly one cycle.
REQ-014 nickel_pulse and dime_pulse SHALL never both be high in the same cycle.
REQ-015 If both channels qualify on the same edge, dime_pulse SHALL fire on that edge and nickel_pulse SHALL fire on the next edge from a one-deep pending flag.
REQ-016 If a new nickel qualifies while the pending flag is set, the pending flag SHALL stay set and the new event SHALL be dropped; this cannot occur when DEBOUNCE_CYCLES>=2.
REQ-017 credit SHALL update on the edge after a pulse: +1 for a nickel, +2 for a dime, saturating at 255 with no wrap.
REQ-018 When credit_clr and a pulse occur in the same cycle, credit SHALL become that pulse's coin value (clear first, then add).
REQ-019 credit_clr with no pulse SHALL set credit to 0 on the next edge.
REQ-020 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-021 rst_n low SHALL immediately force every channel FSM to IDLE and clear all debounce counters, synchronizer flops and the pending flag.
REQ-022 rst_n low SHALL immediately force nickel_pulse=0, dime_pulse=0 and credit=0.
REQ-023 A reset during QUAL, HELD or the pending cycle SHALL produce no event after release.
REQ-024 After rst_n release, a switch that is still held SHALL requalify from IDLE as a new coin.

Structure
REQ-025 Shared package vend_pkg SHALL hold:
  - the channel state enum (IDLE, QUAL, HELD, RELQ);
  - the coin value constants NICKEL_VAL=1 and DIME_VAL=2;
  - the 8-bit credit width constant CREDIT_W.
REQ-026 The per-channel synchronizer, FSM and counter SHALL live in sub-module coin_debounce, instantiated twice.
REQ-027 Arbitration, the pending flag and the credit accumulator SHALL live in coin_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Clean nickel: nickel_raw high from edge 0 for 20 cycles -> one nickel_pulse at edge 5; credit=1 at edge 6; no further pulse.
REQ-029 Bounce: dime_raw toggles every cycle for 10 cycles, then holds high -> no pulse while toggling; exactly one dime_pulse after 4 stable synchronized highs; credit=2.
REQ-030 Simultaneous coins: nickel_raw and dime_raw rise on the same edge -> dime_pulse at edge 5, nickel_pulse at edge 6, credit=3 at edge 7.
REQ-031 Saturation and clear:
  - From credit=254, a dime -> credit=255.
  - Then a nickel coinciding with credit_clr -> credit=1.
REQ-032 Reset mid-qualification: rst_n low at edge 3 of a nickel press, released at edge 5, switch still held -> no pulse before release; one pulse at 1+4 edges after release; credit=1.
REQ-033 Release qualification: switch released for 2 cycles and then pressed again -> no second pulse; a second pulse only after 4 consecutive low samples followed by a new press.
